// File: rtl/tlp_tx_sched.sv
// tlp_tx_sched: packet-level scheduler for the PCIe TX TLP stream (CMP > MTR > F2C with anti-starvation).
// Define TLP_TX_SCHED_STATS_EN to build the per-requester packet counters.
module tlp_tx_sched #(
   parameter int unsigned STARVE_LIMIT = 64
) (
   input  logic        pcieClk_in,
   input  logic        pcieRstN_in,
   input  logic [63:0] cmpData_in,
   input  logic        cmpValid_in,
   input  logic        cmpSop_in,
   input  logic        cmpEop_in,
   output logic        cmpReady_out,
   input  logic [63:0] mtrData_in,
   input  logic        mtrValid_in,
   input  logic        mtrSop_in,
   input  logic        mtrEop_in,
   output logic        mtrReady_out,
   input  logic [63:0] f2cData_in,
   input  logic        f2cValid_in,
   input  logic        f2cSop_in,
   input  logic        f2cEop_in,
   output logic        f2cReady_out,
   output logic [63:0] txData_out,
   output logic        txValid_out,
   output logic        txSop_out,
   output logic        txEop_out,
   input  logic        txReady_in,
   output logic [1:0]  grant_out,
   output logic        protoErr_out,
   output logic [31:0] cmpCount_out,
   output logic [31:0] mtrCount_out,
   output logic [31:0] f2cCount_out
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_CMP  = 2'd1;
   localparam logic [1:0] GNT_MTR  = 2'd2;
   localparam logic [1:0] GNT_F2C  = 2'd3;
   localparam logic [7:0] STARVE_TH = 8'(STARVE_LIMIT);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  grant;
   logic [1:0]  grant_nxt;
   logic [1:0]  winner;
   logic        grant_load;
   logic        beat_accept;
   logic        pkt_done;
   logic        first_beat;
   logic        proto_err;
   logic [7:0]  mtr_wait_cnt;
   logic [7:0]  f2c_wait_cnt;
   logic        cmp_elig;
   logic        mtr_elig;
   logic        f2c_elig;
   logic        mtr_starve;
   logic        f2c_starve;

   assign cmp_elig   = cmpValid_in & cmpSop_in;
   assign mtr_elig   = mtrValid_in & mtrSop_in;
   assign f2c_elig   = f2cValid_in & f2cSop_in;
   assign mtr_starve = (mtr_wait_cnt >= STARVE_TH);
   assign f2c_starve = (f2c_wait_cnt >= STARVE_TH);

   // Starving bulk requesters jump ahead of CMP; otherwise plain fixed priority.
   always_comb begin
      winner = GNT_NONE;
      if (mtr_elig && mtr_starve)
         winner = GNT_MTR;
      else if (f2c_elig && f2c_starve)
         winner = GNT_F2C;
      else if (cmp_elig)
         winner = GNT_CMP;
      else if (mtr_elig)
         winner = GNT_MTR;
      else if (f2c_elig)
         winner = GNT_F2C;
   end

   // Grant is zero outside BUSY, so the mux alone keeps the stream quiet in IDLE.
   always_comb begin
      txData_out   = 64'd0;
      txValid_out  = 1'b0;
      txSop_out    = 1'b0;
      txEop_out    = 1'b0;
      cmpReady_out = 1'b0;
      mtrReady_out = 1'b0;
      f2cReady_out = 1'b0;
      case (grant)
         GNT_CMP: begin
            txData_out   = cmpData_in;
            txValid_out  = cmpValid_in;
            txSop_out    = cmpSop_in;
            txEop_out    = cmpEop_in;
            cmpReady_out = txReady_in;
         end
         GNT_MTR: begin
            txData_out   = mtrData_in;
            txValid_out  = mtrValid_in;
            txSop_out    = mtrSop_in;
            txEop_out    = mtrEop_in;
            mtrReady_out = txReady_in;
         end
         GNT_F2C: begin
            txData_out   = f2cData_in;
            txValid_out  = f2cValid_in;
            txSop_out    = f2cSop_in;
            txEop_out    = f2cEop_in;
            f2cReady_out = txReady_in;
         end
         default: ;
      endcase
   end

   assign beat_accept = txValid_out & txReady_in;
   assign pkt_done    = beat_accept & txEop_out;
   assign grant_load  = (state == IDLE) && (winner != GNT_NONE);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      case (state)
         IDLE: begin
            if (winner != GNT_NONE) begin
               state_nxt = BUSY;
               grant_nxt = winner;
            end
         end
         BUSY: begin
            if (pkt_done) begin
               state_nxt = IDLE;
               grant_nxt = GNT_NONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = GNT_NONE;
         end
      endcase
   end

   always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
      if (!pcieRstN_in) begin
         state <= IDLE;
         grant <= GNT_NONE;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
      end
   end

   // Only the first accepted beat of a grant is checked for Sop; the error is sticky.
   always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
      if (!pcieRstN_in) begin
         first_beat <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         if (grant_load)
            first_beat <= 1'b1;
         else if (beat_accept)
            first_beat <= 1'b0;
         if (first_beat && beat_accept && !txSop_out)
            proto_err <= 1'b1;
      end
   end

   always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
      if (!pcieRstN_in) begin
         mtr_wait_cnt <= 8'd0;
         f2c_wait_cnt <= 8'd0;
      end else begin
         if (grant_load && (winner == GNT_MTR))
            mtr_wait_cnt <= 8'd0;
         else if (mtrValid_in && (grant != GNT_MTR) && (mtr_wait_cnt != 8'hFF))
            mtr_wait_cnt <= mtr_wait_cnt + 8'd1;
         if (grant_load && (winner == GNT_F2C))
            f2c_wait_cnt <= 8'd0;
         else if (f2cValid_in && (grant != GNT_F2C) && (f2c_wait_cnt != 8'hFF))
            f2c_wait_cnt <= f2c_wait_cnt + 8'd1;
      end
   end

   assign grant_out    = grant;
   assign protoErr_out = proto_err;

`ifdef TLP_TX_SCHED_STATS_EN
   logic [31:0] cmp_pkt_cnt;
   logic [31:0] mtr_pkt_cnt;
   logic [31:0] f2c_pkt_cnt;

   always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
      if (!pcieRstN_in) begin
         cmp_pkt_cnt <= 32'd0;
         mtr_pkt_cnt <= 32'd0;
         f2c_pkt_cnt <= 32'd0;
      end else if (pkt_done) begin
         case (grant)
            GNT_CMP: cmp_pkt_cnt <= cmp_pkt_cnt + 32'd1;
            GNT_MTR: mtr_pkt_cnt <= mtr_pkt_cnt + 32'd1;
            GNT_F2C: f2c_pkt_cnt <= f2c_pkt_cnt + 32'd1;
            default: ;
         endcase
      end
   end

   assign cmpCount_out = cmp_pkt_cnt;
   assign mtrCount_out = mtr_pkt_cnt;
   assign f2cCount_out = f2c_pkt_cnt;
`else
   assign cmpCount_out = 32'd0;
   assign mtrCount_out = 32'd0;
   assign f2cCount_out = 32'd0;
`endif

endmodule

// File: tb/tb_tlp_tx_sched.sv
// tb_tlp_tx_sched: table-driven directed vectors for tlp_tx_sched (STARVE_LIMIT=4),
// plus hand-written starvation, protocol-error and packet-count sequences.
module tb_tlp_tx_sched;

   typedef struct {
      logic        rst_n;
      logic [2:0]  cmp_ctl;
      logic [2:0]  mtr_ctl;
      logic [2:0]  f2c_ctl;
      logic [7:0]  beat;
      logic        tx_rdy;
      logic [1:0]  exp_grant;
      logic [2:0]  exp_tx;
      logic [63:0] exp_data;
      logic [2:0]  exp_rdy;
      logic        exp_err;
   } vec_t;

   localparam logic [2:0] NO  = 3'b000;
   localparam logic [2:0] V   = 3'b100;
   localparam logic [2:0] VS  = 3'b110;
   localparam logic [2:0] VE  = 3'b101;
   localparam logic [2:0] VSE = 3'b111;

   logic        pcie_clk;
   logic        pcie_rst_n;
   logic [63:0] cmp_data, mtr_data, f2c_data;
   logic        cmp_valid, cmp_sop, cmp_eop, cmp_ready;
   logic        mtr_valid, mtr_sop, mtr_eop, mtr_ready;
   logic        f2c_valid, f2c_sop, f2c_eop, f2c_ready;
   logic [63:0] tx_data;
   logic        tx_valid, tx_sop, tx_eop, tx_ready;
   logic [1:0]  grant;
   logic        proto_err;
   logic [31:0] cmp_count, mtr_count, f2c_count;

   int tests_run    = 0;
   int tests_failed = 0;
   vec_t vecs[$];

   tlp_tx_sched #(.STARVE_LIMIT(4)) dut (
      .pcieClk_in   (pcie_clk),
      .pcieRstN_in  (pcie_rst_n),
      .cmpData_in   (cmp_data),
      .cmpValid_in  (cmp_valid),
      .cmpSop_in    (cmp_sop),
      .cmpEop_in    (cmp_eop),
      .cmpReady_out (cmp_ready),
      .mtrData_in   (mtr_data),
      .mtrValid_in  (mtr_valid),
      .mtrSop_in    (mtr_sop),
      .mtrEop_in    (mtr_eop),
      .mtrReady_out (mtr_ready),
      .f2cData_in   (f2c_data),
      .f2cValid_in  (f2c_valid),
      .f2cSop_in    (f2c_sop),
      .f2cEop_in    (f2c_eop),
      .f2cReady_out (f2c_ready),
      .txData_out   (tx_data),
      .txValid_out  (tx_valid),
      .txSop_out    (tx_sop),
      .txEop_out    (tx_eop),
      .txReady_in   (tx_ready),
      .grant_out    (grant),
      .protoErr_out (proto_err),
      .cmpCount_out (cmp_count),
      .mtrCount_out (mtr_count),
      .f2cCount_out (f2c_count)
   );

   initial pcie_clk = 1'b0;
   always #5 pcie_clk = ~pcie_clk;

   function automatic vec_t mk(input logic rst_n, input logic [2:0] c, input logic [2:0] m,
                               input logic [2:0] f, input logic [7:0] beat, input logic rdy,
                               input logic [1:0] g, input logic [2:0] tx, input logic [63:0] d,
                               input logic [2:0] r, input logic err);
      vec_t v;
      v.rst_n = rst_n; v.cmp_ctl = c; v.mtr_ctl = m; v.f2c_ctl = f;
      v.beat = beat; v.tx_rdy = rdy; v.exp_grant = g; v.exp_tx = tx;
      v.exp_data = d; v.exp_rdy = r; v.exp_err = err;
      return v;
   endfunction

   function automatic logic [63:0] qw(input logic [7:0] tag, input logic [7:0] beat);
      return {tag, 48'd0, beat};
   endfunction

   task automatic check_val(input string tag, input string name, input logic [63:0] got,
                            input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s %s: got %0h, expected %0h", tag, name, got, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      pcie_rst_n = v.rst_n;
      {cmp_valid, cmp_sop, cmp_eop} = v.cmp_ctl;
      {mtr_valid, mtr_sop, mtr_eop} = v.mtr_ctl;
      {f2c_valid, f2c_sop, f2c_eop} = v.f2c_ctl;
      cmp_data = qw(8'hC0, v.beat);
      mtr_data = qw(8'hA0, v.beat);
      f2c_data = qw(8'hF0, v.beat);
      tx_ready = v.tx_rdy;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      check_val(tag, "grant", 64'(grant), 64'(v.exp_grant));
      check_val(tag, "tx_vse", 64'({tx_valid, tx_sop, tx_eop}), 64'(v.exp_tx));
      check_val(tag, "tx_data", tx_data, v.exp_data);
      check_val(tag, "ready", 64'({cmp_ready, mtr_ready, f2c_ready}), 64'(v.exp_rdy));
      check_val(tag, "proto_err", 64'(proto_err), 64'(v.exp_err));
   endtask

   // Inputs change on the falling edge; outputs are sampled mid-low-phase, before the rising edge.
   task automatic run_row(input vec_t v, input string tag);
      @(negedge pcie_clk);
      applyStimulus(v);
      #2;
      checkOutput(v, tag);
   endtask

   initial begin
      vec_t rst_row;
      vec_t v;
      logic [31:0] exp_cmp_cnt, exp_mtr_cnt, exp_f2c_cnt;

      pcie_rst_n = 1'b0;
      cmp_valid = 0; cmp_sop = 0; cmp_eop = 0; cmp_data = 0;
      mtr_valid = 0; mtr_sop = 0; mtr_eop = 0; mtr_data = 0;
      f2c_valid = 0; f2c_sop = 0; f2c_eop = 0; f2c_data = 0;
      tx_ready = 1'b1;
      rst_row = mk(0, NO, NO, NO, 0, 1, 0, NO, 0, 0, 0);

      // CMP 2-beat packet alone
      vecs.push_back(rst_row);
      vecs.push_back(mk(1, VS, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, VS, NO, NO, 0, 1, 1, VS, 64'hC000_0000_0000_0000, 3'b100, 0));
      vecs.push_back(mk(1, VE, NO, NO, 1, 1, 1, VE, 64'hC000_0000_0000_0001, 3'b100, 0));
      vecs.push_back(mk(1, NO, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0));
      // CMP and F2C (8 beats) together: CMP first, one bubble, then F2C in order
      vecs.push_back(rst_row);
      vecs.push_back(mk(1, VS, NO, VS, 0, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, VS, NO, VS, 0, 1, 1, VS, 64'hC000_0000_0000_0000, 3'b100, 0));
      vecs.push_back(mk(1, VE, NO, VS, 1, 1, 1, VE, 64'hC000_0000_0000_0001, 3'b100, 0));
      vecs.push_back(mk(1, NO, NO, VS, 0, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, NO, NO, VS, 0, 1, 3, VS, 64'hF000_0000_0000_0000, 3'b001, 0));
      for (int k = 1; k < 7; k++)
         vecs.push_back(mk(1, NO, NO, V, 8'(k), 1, 3, V, qw(8'hF0, 8'(k)), 3'b001, 0));
      vecs.push_back(mk(1, NO, NO, VE, 7, 1, 3, VE, 64'hF000_0000_0000_0007, 3'b001, 0));
      vecs.push_back(mk(1, NO, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0));
      // F2C back-pressure 1,0,0,1 plus a stalled EOP beat
      vecs.push_back(rst_row);
      vecs.push_back(mk(1, NO, NO, VS, 0, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, NO, NO, VS, 0, 1, 3, VS, 64'hF000_0000_0000_0000, 3'b001, 0));
      vecs.push_back(mk(1, NO, NO, V, 1, 0, 3, V, 64'hF000_0000_0000_0001, 3'b000, 0));
      vecs.push_back(mk(1, NO, NO, V, 1, 0, 3, V, 64'hF000_0000_0000_0001, 3'b000, 0));
      vecs.push_back(mk(1, NO, NO, V, 1, 1, 3, V, 64'hF000_0000_0000_0001, 3'b001, 0));
      vecs.push_back(mk(1, NO, NO, VE, 2, 0, 3, VE, 64'hF000_0000_0000_0002, 3'b000, 0));
      vecs.push_back(mk(1, NO, NO, VE, 2, 1, 3, VE, 64'hF000_0000_0000_0002, 3'b001, 0));
      vecs.push_back(mk(1, NO, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0));
      // Valid drops mid-packet (grant held), then async reset mid-packet
      vecs.push_back(rst_row);
      vecs.push_back(mk(1, VS, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, VS, NO, NO, 0, 1, 1, VS, 64'hC000_0000_0000_0000, 3'b100, 0));
      vecs.push_back(mk(1, NO, NO, NO, 1, 1, 1, NO, 64'hC000_0000_0000_0001, 3'b100, 0));
      vecs.push_back(mk(0, VE, NO, NO, 1, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, NO, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0));
      // MTR beats F2C without starvation; single-beat packets
      vecs.push_back(rst_row);
      vecs.push_back(mk(1, NO, VSE, VSE, 0, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, NO, VSE, VSE, 0, 1, 2, VSE, 64'hA000_0000_0000_0000, 3'b010, 0));
      vecs.push_back(mk(1, NO, NO, VSE, 0, 1, 0, NO, 0, 3'b000, 0));
      vecs.push_back(mk(1, NO, NO, VSE, 0, 1, 3, VSE, 64'hF000_0000_0000_0000, 3'b001, 0));
      vecs.push_back(mk(1, NO, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0));

      foreach (vecs[i])
         run_row(vecs[i], $sformatf("vec%0d", i));

      // Starvation: CMP back-to-back 2-beat packets, MTR single-beat pending, limit 4
      run_row(rst_row, "stv_rst");
      run_row(mk(1, VS, VSE, NO, 0, 1, 0, NO, 0, 3'b000, 0), "stv0");
      run_row(mk(1, VS, VSE, NO, 0, 1, 1, VS, 64'hC000_0000_0000_0000, 3'b100, 0), "stv1");
      run_row(mk(1, VE, VSE, NO, 1, 1, 1, VE, 64'hC000_0000_0000_0001, 3'b100, 0), "stv2");
      run_row(mk(1, VS, VSE, NO, 0, 1, 0, NO, 0, 3'b000, 0), "stv3");
      check_val("stv3", "mtr_wait_cnt", 64'(dut.mtr_wait_cnt), 64'd3);
      run_row(mk(1, VS, VSE, NO, 0, 1, 1, VS, 64'hC000_0000_0000_0000, 3'b100, 0), "stv4");
      run_row(mk(1, VE, VSE, NO, 1, 1, 1, VE, 64'hC000_0000_0000_0001, 3'b100, 0), "stv5");
      run_row(mk(1, VS, VSE, NO, 0, 1, 0, NO, 0, 3'b000, 0), "stv6");
      run_row(mk(1, VS, VSE, NO, 0, 1, 2, VSE, 64'hA000_0000_0000_0000, 3'b010, 0), "stv7");
      check_val("stv7", "mtr_wait_cnt", 64'(dut.mtr_wait_cnt), 64'd0);
      run_row(mk(1, VS, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0), "stv8");
      run_row(mk(1, VS, NO, NO, 0, 1, 1, VS, 64'hC000_0000_0000_0000, 3'b100, 0), "stv9");

      // Granted MTR first beat lacks Sop: sticky error, packet still forwarded
      run_row(rst_row, "perr_rst");
      run_row(mk(1, NO, VS, NO, 0, 1, 0, NO, 0, 3'b000, 0), "perr0");
      run_row(mk(1, NO, V, NO, 0, 1, 2, V, 64'hA000_0000_0000_0000, 3'b010, 0), "perr1");
      run_row(mk(1, NO, V, NO, 1, 1, 2, V, 64'hA000_0000_0000_0001, 3'b010, 1), "perr2");
      run_row(mk(1, NO, VE, NO, 2, 1, 2, VE, 64'hA000_0000_0000_0002, 3'b010, 1), "perr3");
      run_row(mk(1, VS, NO, NO, 0, 1, 0, NO, 0, 3'b000, 1), "perr4");
      run_row(mk(1, VS, NO, NO, 0, 1, 1, VS, 64'hC000_0000_0000_0000, 3'b100, 1), "perr5");
      run_row(rst_row, "perr_clr");

      // Packet counters: 3 CMP then 5 F2C single-beat packets
      run_row(rst_row, "cnt_rst");
      check_val("cnt_rst", "cmp_count", 64'(cmp_count), 64'd0);
      for (int i = 0; i < 3; i++) begin
         run_row(mk(1, VSE, NO, NO, 8'(i), 1, 0, NO, 0, 3'b000, 0), $sformatf("cnt_c%0d_idle", i));
         run_row(mk(1, VSE, NO, NO, 8'(i), 1, 1, VSE, qw(8'hC0, 8'(i)), 3'b100, 0),
                 $sformatf("cnt_c%0d_busy", i));
      end
      for (int i = 0; i < 5; i++) begin
         run_row(mk(1, NO, NO, VSE, 8'(i), 1, 0, NO, 0, 3'b000, 0), $sformatf("cnt_f%0d_idle", i));
         run_row(mk(1, NO, NO, VSE, 8'(i), 1, 3, VSE, qw(8'hF0, 8'(i)), 3'b001, 0),
                 $sformatf("cnt_f%0d_busy", i));
      end
      v = mk(1, NO, NO, NO, 0, 1, 0, NO, 0, 3'b000, 0);
      run_row(v, "cnt_end");
`ifdef TLP_TX_SCHED_STATS_EN
      exp_cmp_cnt = 32'd3; exp_mtr_cnt = 32'd0; exp_f2c_cnt = 32'd5;
`else
      exp_cmp_cnt = 32'd0; exp_mtr_cnt = 32'd0; exp_f2c_cnt = 32'd0;
`endif
      check_val("cnt_end", "cmp_count", 64'(cmp_count), 64'(exp_cmp_cnt));
      check_val("cnt_end", "mtr_count", 64'(mtr_count), 64'(exp_mtr_cnt));
      check_val("cnt_end", "f2c_count", 64'(f2c_count), 64'(exp_f2c_cnt));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tlp_tx_sched.md
# tlp_tx_sched

Packet-level scheduler for the single 64-bit TLP transmit stream into the PCIe hard IP. Three requesters share it: register-read completions (CMP), metrics-buffer DMA writes (MTR) and FPGA->CPU chunk DMA writes (F2C). It grants the stream to one requester at a time and holds the grant from SOP to EOP, so TLPs are never interleaved. Fixed priority applies, with an anti-starvation override. It sits between the TLP formatters and the core's TX Avalon-ST port.

## Interface
Parameters:
- STARVE_LIMIT, 64: cycles a pending MTR/F2C packet may wait before being promoted above CMP (1..255).

Ports:
- pcieClk_in  in  1  sole clock
- pcieRstN_in  in  1  asynchronous, active-low reset
- {cmp,mtr,f2c}Data_in  in  64  requester QW beat
- {cmp,mtr,f2c}Valid_in  in  1  beat valid
- {cmp,mtr,f2c}Sop_in  in  1  first QW of TLP
- {cmp,mtr,f2c}Eop_in  in  1  last QW of TLP
- {cmp,mtr,f2c}Ready_out  out  1  beat accepted when Valid&Ready
- txData_out  out  64  beat to core
- txValid_out  out  1  beat valid
- txSop_out  out  1  start of packet
- txEop_out  out  1  end of packet
- txReady_in  in  1  core accepts beat (zero-latency ready)
- grant_out  out  2  0 none, 1 CMP, 2 MTR, 3 F2C
- protoErr_out  out  1  sticky: granted requester presented Valid without Sop on its first beat
- {cmp,mtr,f2c}Count_out  out  32  packets sent (see Configuration)

## Operation
- States: IDLE, BUSY.
- A requester is eligible when Valid_in&Sop_in are both high.
- IDLE: if any requester is eligible, register the winner into grant and go to BUSY. No beat moves in IDLE.
- Priority: a starving requester wins first, MTR before F2C. Otherwise CMP > MTR > F2C.
- Starvation counters exist for MTR and F2C only: 8-bit, saturating at 255.
  - Increment every cycle the requester's Valid_in is high and it is not granted.
  - Clear in the cycle its grant is registered.
  - "Starving" means counter >= STARVE_LIMIT.
- BUSY, datapath:
  - txData/Sop/Eop/Valid_out = granted requester's inputs.
  - Granted Ready_out = txReady_in; ungranted Ready_out = 0.
- BUSY, exit: when txValid_out&txReady_in&txEop_out, return to IDLE (grant_out -> 0 next cycle).
- Protocol check: in BUSY, the first beat must carry Sop. If it does not, set protoErr_out, still forward the beat, and keep the grant until Eop.
- Sop on a non-first beat is forwarded unchanged and not checked.
- Single-beat packet (Sop&Eop both high): legal; BUSY lasts until that beat is accepted.
- Back-pressure: txReady_in low holds all state; beats are neither dropped nor duplicated.

## Timing
- Reset values:
  - State IDLE; grant_out 0.
  - txValid/Sop/Eop_out 0; txData_out 0.
  - All Ready_out 0; protoErr_out 0; counters 0.
- Arbitration latency: an eligible requester seen in IDLE at cycle N has its first beat on txData_out at N+1.
- One idle bubble between consecutive packets; maximum throughput is L/(L+1) for L-beat packets.
- Ready_out and tx* outputs are combinational from the registered grant and from txReady_in/requester inputs. There is no path from requester inputs to grant within a cycle.
- Simultaneous events: the EOP accept and a new request in the same cycle are handled as IDLE next cycle, grant registered the cycle after. A requester deasserting Valid mid-packet keeps its grant; the stream stalls.
- Reset mid-packet: state aborts immediately with no EOP emitted. The core is reset in the same domain.

## Configuration
- TLP_TX_SCHED_STATS_EN defined: each Count_out is a 32-bit wrapping counter. It increments on the accepted EOP beat of that requester's packet; reset is 0.
- Undefined: the counters are not built and Count_out is tied to 0. Arbitration behaviour is identical.

## Test plan
- CMP 2-beat packet alone, txReady_in=1 -> grant_out=1 one cycle after request; beats appear on cycles N+1, N+2 with Sop then Eop; grant_out=0 at N+3.
- CMP and F2C (8 beats) request in the same cycle -> CMP packet first, one bubble, then F2C's 8 beats in order; no interleave.
- STARVE_LIMIT=4, CMP issues back-to-back 2-beat packets, MTR pending -> MTR is granted after the CMP packet in flight once its counter reaches 4; after MTR's grant its counter reads 0.
- txReady_in toggles 1,0,0,1 during an F2C packet -> f2cReady_out mirrors it; every beat appears exactly once on txData_out, in order.
- Granted MTR first beat has Valid=1, Sop=0 -> protoErr_out=1 from the next cycle and stays 1 until reset; the packet is still forwarded to Eop.
- With TLP_TX_SCHED_STATS_EN: 3 CMP + 5 F2C packets sent -> cmpCount_out=3, f2cCount_out=5, mtrCount_out=0. Without the macro -> all counts 0.
